// File: rtl/crc_slice_pkg.sv
// Shared constants and table generator for the sliced CRC-32 engine.
// Contents:
//   CRC_W        - CRC state width (32)
//   MAX_SLICES   - number of lookup tables the engine carries (8)
//   DEF_POLY     - reflected CRC-32 polynomial
//   DEF_INIT     - state loaded at message start
//   DEF_XOROUT   - value XORed into the final CRC
//   crc_t        - CRC-width word
//   crc_tab_entry(slice, index, poly) - elaboration-time table entry builder
package crc_slice_pkg;

  localparam int unsigned CRC_W      = 32;
  localparam int unsigned MAX_SLICES = 8;

  localparam logic [CRC_W-1:0] DEF_POLY   = 32'hEDB88320;
  localparam logic [CRC_W-1:0] DEF_INIT   = 32'hFFFFFFFF;
  localparam logic [CRC_W-1:0] DEF_XOROUT = 32'hFFFFFFFF;

  typedef logic [CRC_W-1:0] crc_t;

  // Effect on a zero state of byte `index` followed by `slice` zero bytes:
  // 8*(slice+1) reflected shift steps starting from the byte itself.
  function automatic logic [CRC_W-1:0] crc_tab_entry(input int unsigned      slice,
                                                     input logic [7:0]       index,
                                                     input logic [CRC_W-1:0] poly);
    logic [CRC_W-1:0] c;
    c = {24'h000000, index};
    for (int unsigned n = 0; n < 8 * (slice + 1); n++) begin
      c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_tab_rom.sv
// 256-entry x 32-bit combinational CRC lookup table for one slice.
// Entry i is the CRC contribution of byte i followed by SLICE zero bytes.
// Ports:
//   idx - table index (one byte)
//   val - table entry
module crc_tab_rom
  import crc_slice_pkg::*;
#(
  parameter int unsigned      SLICE = 0,
  parameter logic [CRC_W-1:0] POLY  = DEF_POLY
) (
  input  logic [7:0]       idx,
  output logic [CRC_W-1:0] val
);

  logic [CRC_W-1:0] tab [256];

  for (genvar i = 0; i < 256; i++) begin : g_ent
    // Evaluated at elaboration, so each entry is a constant.
    localparam logic [CRC_W-1:0] Entry = crc_tab_entry(SLICE, 8'(i), POLY);
    assign tab[i] = Entry;
  end

  assign val = tab[idx];

endmodule

// File: rtl/crc_slice_engine.sv
// Streaming reflected CRC-32 engine, NBYTES bytes per beat, slicing-by-k.
// Three register stages: A (beat capture), B (CRC state update), C (result).
// Ports:
//   clk, rstn          - clock, asynchronous active-low reset
//   s_valid/s_ready    - input beat handshake
//   s_data             - beat data, lane 0 (s_data[7:0]) processed first
//   s_last             - final beat of a message
//   s_nbytes           - valid lanes on the last beat (0 or >NBYTES = full beat)
//   m_valid/m_ready    - result handshake
//   m_crc              - final CRC of the message
module crc_slice_engine
  import crc_slice_pkg::*;
#(
  parameter int unsigned      NBYTES = 4,
  parameter logic [CRC_W-1:0] POLY   = DEF_POLY,
  parameter logic [CRC_W-1:0] INIT   = DEF_INIT,
  parameter logic [CRC_W-1:0] XOROUT = DEF_XOROUT
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [8*NBYTES-1:0]       s_data,
  input  logic                      s_last,
  input  logic [$clog2(NBYTES):0]   s_nbytes,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [CRC_W-1:0]          m_crc
);

  logic stall;

  // Stage A
  logic                a_valid_q;
  logic                a_last_q;
  logic [3:0]          a_k_q;
  logic [8*NBYTES-1:0] a_data_q;
  logic [3:0]          k_in;

  // Stage B
  crc_t state_q;
  logic b_valid_q;  // a finished message's CRC sits in b_crc_q
  crc_t b_crc_q;
  crc_t upd;

  // Stage C
  logic m_valid_q;
  crc_t m_crc_q;

  // Slice datapath
  logic [63:0] data_w;
  logic [7:0]  xb      [MAX_SLICES];
  logic [7:0]  rom_idx [MAX_SLICES];
  crc_t        rom_val [MAX_SLICES];

  assign stall   = m_valid_q & ~m_ready;
  assign s_ready = ~stall;
  assign m_valid = m_valid_q;
  assign m_crc   = m_crc_q;

  // Lane count: full beat unless a last beat names a legal partial count.
  always_comb begin
    k_in = 4'(NBYTES);
    if (s_last && (s_nbytes != '0) && (4'(s_nbytes) <= 4'(NBYTES))) begin
      k_in = 4'(s_nbytes);
    end
  end

  // State folds into the low four lanes; slice s serves lane k-1-s.
  always_comb begin
    data_w = '0;
    data_w[8*NBYTES-1:0] = a_data_q;
    for (int j = 0; j < 4; j++) begin
      xb[j] = data_w[8*j +: 8] ^ state_q[8*j +: 8];
    end
    for (int j = 4; j < 8; j++) begin
      xb[j] = data_w[8*j +: 8];
    end
    for (int s = 0; s < 8; s++) begin
      rom_idx[s] = '0;
      if (4'(s) < a_k_q) begin
        rom_idx[s] = xb[3'(a_k_q - 4'(s) - 4'd1)];
      end
    end
  end

  for (genvar g = 0; g < MAX_SLICES; g++) begin : g_rom
    crc_tab_rom #(
      .SLICE (g),
      .POLY  (POLY)
    ) u_rom (
      .idx (rom_idx[g]),
      .val (rom_val[g])
    );
  end

  // State bytes not consumed by a short beat simply shift down.
  always_comb begin
    upd = '0;
    for (int s = 0; s < 8; s++) begin
      if (4'(s) < a_k_q) begin
        upd = upd ^ rom_val[s];
      end
    end
    if (a_k_q < 4'd4) begin
      upd = upd ^ (state_q >> {a_k_q[1:0], 3'b000});
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_valid_q <= 1'b0;
      a_last_q  <= 1'b0;
      a_k_q     <= '0;
      a_data_q  <= '0;
    end else if (!stall) begin
      a_valid_q <= s_valid;
      if (s_valid) begin
        a_data_q <= s_data;
        a_last_q <= s_last;
        a_k_q    <= k_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= INIT;
      b_valid_q <= 1'b0;
      b_crc_q   <= '0;
    end else if (!stall) begin
      b_valid_q <= a_valid_q & a_last_q;
      if (a_valid_q) begin
        state_q <= a_last_q ? INIT : upd;
        b_crc_q <= upd;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid_q <= 1'b0;
      m_crc_q   <= '0;
    end else if (!stall) begin
      // Clears on handshake unless a new result arrives on the same edge.
      m_valid_q <= b_valid_q;
      if (b_valid_q) begin
        m_crc_q <= b_crc_q ^ XOROUT;
      end
    end
  end

endmodule

// File: tb/tb_crc_slice_engine.sv
// Self-checking bench for crc_slice_engine: directed vectors on NBYTES=4, 8 and 1,
// a table of known CRC-32 messages, stall and reset sequences, and randomized
// messages with bubbles and random m_ready against a bytewise CRC model.
module tb_crc_slice_engine;

  typedef logic [7:0] bq_t [$];

  typedef struct {
    int          len;
    logic [127:0] bytes;
    logic [31:0]  crc;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // NBYTES=4 instance
  logic        s_valid4  = 1'b0;
  logic        s_ready4;
  logic [31:0] s_data4   = '0;
  logic        s_last4   = 1'b0;
  logic [2:0]  s_nbytes4 = '0;
  logic        m_valid4;
  logic        m_ready4  = 1'b1;
  logic [31:0] m_crc4;

  // NBYTES=8 instance
  logic        s_valid8  = 1'b0;
  logic        s_ready8;
  logic [63:0] s_data8   = '0;
  logic        s_last8   = 1'b0;
  logic [3:0]  s_nbytes8 = '0;
  logic        m_valid8;
  logic [31:0] m_crc8;

  // NBYTES=1 instance
  logic        s_valid1  = 1'b0;
  logic        s_ready1;
  logic [7:0]  s_data1   = '0;
  logic        s_last1   = 1'b0;
  logic [0:0]  s_nbytes1 = '0;
  logic        m_valid1;
  logic [31:0] m_crc1;

  crc_slice_engine #(.NBYTES(4)) dut4 (
    .clk (clk), .rstn (rstn),
    .s_valid (s_valid4), .s_ready (s_ready4), .s_data (s_data4), .s_last (s_last4),
    .s_nbytes (s_nbytes4), .m_valid (m_valid4), .m_ready (m_ready4), .m_crc (m_crc4)
  );

  crc_slice_engine #(.NBYTES(8)) dut8 (
    .clk (clk), .rstn (rstn),
    .s_valid (s_valid8), .s_ready (s_ready8), .s_data (s_data8), .s_last (s_last8),
    .s_nbytes (s_nbytes8), .m_valid (m_valid8), .m_ready (1'b1), .m_crc (m_crc8)
  );

  crc_slice_engine #(.NBYTES(1)) dut1 (
    .clk (clk), .rstn (rstn),
    .s_valid (s_valid1), .s_ready (s_ready1), .s_data (s_data1), .s_last (s_last1),
    .s_nbytes (s_nbytes1), .m_valid (m_valid1), .m_ready (1'b1), .m_crc (m_crc1)
  );

  // Results accepted by dut4, in order.
  logic [31:0] got4 [$];
  always @(negedge clk) begin
    if (rstn && m_valid4 && m_ready4) got4.push_back(m_crc4);
  end

  // Plain bytewise reflected CRC-32.
  function automatic logic [31:0] crc_ref(input bq_t msg);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (msg[i]) begin
      c = c ^ {24'h0, msg[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c ^ 32'hFFFFFFFF;
  endfunction

  function automatic bq_t to_q(input logic [127:0] v, input int len);
    bq_t q;
    for (int i = 0; i < len; i++) q.push_back(v[8*i +: 8]);
    return q;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sends one message to dut4. Called at posedge+1; returns at posedge+1 after the
  // last beat's transfer edge. vary: random s_nbytes encodings where ignored/full.
  task automatic send4(input bq_t msg, input bit vary, input bit bubbles);
    int  n;
    int  nb;
    bit  ok;
    int  guard;
    n  = msg.size();
    nb = (n + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      logic [31:0] d;
      int          cnt;
      d   = $urandom();
      cnt = 0;
      for (int l = 0; l < 4; l++) begin
        if (4*b + l < n) begin
          d[8*l +: 8] = msg[4*b + l];
          cnt++;
        end
      end
      if (bubbles) begin
        while ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      s_valid4 = 1'b1;
      s_data4  = d;
      s_last4  = (b == nb - 1);
      if (b != nb - 1) begin
        s_nbytes4 = vary ? 3'($urandom_range(0, 7)) : 3'd4;
      end else if (cnt == 4 && vary) begin
        int v;
        v = $urandom_range(4, 8);
        s_nbytes4 = (v == 8) ? 3'd0 : 3'(v);
      end else begin
        s_nbytes4 = 3'(cnt);
      end
      guard = 0;
      do begin
        @(negedge clk);
        ok = s_ready4;
        @(posedge clk);
        #1;
        guard++;
      end while (!ok && guard < 1000);
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL s_ready_timeout: s_ready stayed %0b, required 1", ok);
      end
      s_valid4 = 1'b0;
      s_last4  = 1'b0;
      s_data4  = $urandom();
    end
  endtask

  task automatic wait_got(input int n, input int budget);
    int cyc;
    cyc = 0;
    while (got4.size() < n && cyc < budget) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check_int("result_count", got4.size(), n);
  endtask

  vec_t        tab [7];
  logic [31:0] exp4 [$];
  bit          rand_done;

  initial begin
    int   base;
    int   cyc;
    bq_t  m9;
    bq_t  msg;

    m9 = to_q(128'h39_3837_3635_3433_3231, 9);
    tab[0] = '{9,  128'h39_3837_3635_3433_3231, 32'hCBF43926};
    tab[1] = '{1,  128'h61, 32'hE8B7BE43};
    tab[2] = '{3,  128'h636261, 32'h352441C2};
    tab[3] = '{4,  128'h64636261, 32'hED82CD11};
    tab[4] = '{1,  128'h00, 32'hD202EF8D};
    tab[5] = '{4,  128'h00000000, 32'h2144DF1C};
    tab[6] = '{14, 128'h7473_6567_6964_2065_6761_7373_656d, 32'h20159D7F};

    // Reset state
    @(negedge clk);
    check32("rst_m_valid4", 32'(m_valid4), 32'd0);
    check32("rst_m_crc4", m_crc4, 32'd0);
    check32("rst_s_ready4", 32'(s_ready4), 32'd1);
    check32("rst_s_ready8", 32'(s_ready8), 32'd1);
    check32("rst_s_ready1", 32'(s_ready1), 32'd1);
    check32("rst_m_valid8", 32'(m_valid8), 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;

    // "123456789" with two-cycle latency check
    base = got4.size();
    send4(m9, 1'b0, 1'b0);
    @(negedge clk);
    check32("lat_after_e0", 32'(m_valid4), 32'd0);
    @(posedge clk); #1; @(negedge clk);
    check32("lat_after_e1", 32'(m_valid4), 32'd0);
    @(posedge clk); #1; @(negedge clk);
    check32("lat_after_e2", 32'(m_valid4), 32'd1);
    check32("crc_123456789", m_crc4, 32'hCBF43926);
    @(posedge clk); #1; @(negedge clk);
    check32("m_valid_clears", 32'(m_valid4), 32'd0);
    @(posedge clk); #1;

    // Known-answer table, back-to-back
    base = got4.size();
    for (int i = 0; i < 7; i++) send4(to_q(tab[i].bytes, tab[i].len), 1'b1, 1'b0);
    wait_got(base + 7, 100);
    for (int i = 0; i < 7; i++) begin
      if (base + i < got4.size()) check32($sformatf("table_%0d", i), got4[base + i], tab[i].crc);
    end

    // Stall: two messages back-to-back, m_ready low for 5 cycles after first m_valid
    base = got4.size();
    m_ready4 = 1'b0;
    fork
      begin
        send4(m9, 1'b0, 1'b0);
        send4(m9, 1'b0, 1'b0);
      end
      begin
        cyc = 0;
        do begin
          @(negedge clk);
          cyc++;
        end while (!m_valid4 && cyc < 50);
        check32("stall_first_valid", 32'(m_valid4), 32'd1);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          check32("stall_s_ready", 32'(s_ready4), 32'd0);
          check32("stall_hold_crc", m_crc4, 32'hCBF43926);
          @(posedge clk);
        end
        #1 m_ready4 = 1'b1;
      end
    join
    wait_got(base + 2, 100);
    repeat (10) @(posedge clk);
    #1;
    check_int("stall_no_dup", got4.size(), base + 2);
    for (int i = 0; i < 2; i++) begin
      if (base + i < got4.size()) check32($sformatf("stall_res_%0d", i), got4[base + i], 32'hCBF43926);
    end

    // Reset in mid-message
    base = got4.size();
    s_valid4 = 1'b1; s_data4 = 32'h34333231; s_last4 = 1'b0; s_nbytes4 = 3'd4;
    @(posedge clk); #1;
    s_valid4 = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    check32("midrst_m_valid", 32'(m_valid4), 32'd0);
    check32("midrst_s_ready", 32'(s_ready4), 32'd1);
    @(posedge clk);
    #1 rstn = 1'b1;
    send4(m9, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check_int("midrst_count", got4.size(), base + 1);
    if (base < got4.size()) check32("midrst_crc", got4[base], 32'hCBF43926);

    // Randomized messages, bubbles, random m_ready
    base = got4.size();
    exp4 = {};
    rand_done = 1'b0;
    fork
      begin
        for (int m = 0; m < 40; m++) begin
          msg = {};
          for (int i = 0; i < $urandom_range(1, 19); i++) msg.push_back(8'($urandom()));
          exp4.push_back(crc_ref(msg));
          send4(msg, 1'b1, 1'b1);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 m_ready4 = ($urandom_range(0, 2) != 0);
        end
        m_ready4 = 1'b1;
      end
    join
    wait_got(base + 40, 2000);
    for (int i = 0; i < 40; i++) begin
      if (base + i < got4.size()) check32($sformatf("rand_%0d", i), got4[base + i], exp4[i]);
    end

    // NBYTES=8: "12345678" + "9" as a one-lane last beat
    s_valid8 = 1'b1; s_data8 = 64'h3837363534333231; s_last8 = 1'b0;
    s_nbytes8 = 4'($urandom_range(0, 15));
    @(posedge clk); #1;
    s_data8 = {32'($urandom()), 32'($urandom())};
    s_data8[7:0] = 8'h39; s_last8 = 1'b1; s_nbytes8 = 4'd1;
    @(posedge clk); #1;
    s_valid8 = 1'b0; s_last8 = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!m_valid8 && cyc < 20);
    check32("d8_valid", 32'(m_valid8), 32'd1);
    check32("d8_crc", m_crc8, 32'hCBF43926);
    @(posedge clk); #1;

    // NBYTES=8: full 8-byte last beat with nbytes encoded as 0 or >8
    msg = {};
    for (int i = 0; i < 8; i++) msg.push_back(8'($urandom()));
    s_valid8 = 1'b1; s_last8 = 1'b1;
    for (int i = 0; i < 8; i++) s_data8[8*i +: 8] = msg[i];
    s_nbytes8 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
    @(posedge clk); #1;
    s_valid8 = 1'b0; s_last8 = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!m_valid8 && cyc < 20);
    check32("d8_full_valid", 32'(m_valid8), 32'd1);
    check32("d8_full_crc", m_crc8, crc_ref(msg));
    @(posedge clk); #1;

    // NBYTES=1: single 0x00 byte, then "a" with nbytes=0 (treated as 1)
    s_valid1 = 1'b1; s_data1 = 8'h00; s_last1 = 1'b1; s_nbytes1 = 1'b1;
    @(posedge clk); #1;
    s_valid1 = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!m_valid1 && cyc < 20);
    check32("d1_zero_crc", m_crc1, 32'hD202EF8D);
    @(posedge clk); #1;
    s_valid1 = 1'b1; s_data1 = 8'h61; s_last1 = 1'b1; s_nbytes1 = 1'b0;
    @(posedge clk); #1;
    s_valid1 = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!m_valid1 && cyc < 20);
    check32("d1_a_crc", m_crc1, 32'hE8B7BE43);
    check32("d1_s_ready", 32'(s_ready1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $fatal(1);
  end

endmodule
